ledg_pattern_sequencer: RTL and testbench

- Avalon-MM slave holding a short LED pattern table, plus a step timer.
- An Avalon-MM master-side write port drives the existing 9-bit green-LED PIO slave (register offset 0) once per step.
- Lets the Nios II software start a self-running LED animation (single-shot or looping) and then leave it alone; the PIO keeps the last written value.

---
 rtl/ledg_pattern_sequencer.sv | 203 ++++++++++++++++++++
 tb/tb_ledg_pattern_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ledg_pattern_sequencer.sv
// Purpose: Avalon-MM LED pattern table plus step timer; plays the table into the green-LED PIO.
// Latency: first PIO write strobe starts one cycle after RUN is written; strobes are max(PERIOD,1)+1 cycles apart.
// Backpressure: none; zero-wait-state slave, and the PIO slave always accepts the single-cycle write.
module ledg_pattern_sequencer #(
   parameter int DATA_W   = 9,
   parameter int DEPTH    = 8,
   parameter int PERIOD_W = 24
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        pio_chipselect,
   output logic        pio_write_n,
   output logic [1:0]  pio_address,
   output logic [31:0] pio_writedata,
   output logic        busy
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STROBE = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t              state;
   logic                run;
   logic                loop;
   logic                done;
   logic [PERIOD_W-1:0] period;
   logic [IDX_W-1:0]    last;
   logic [IDX_W-1:0]    idx;
   logic [PERIOD_W-1:0] cnt;
   logic [DATA_W-1:0]   pattern [DEPTH];

   // Slave write decode
   logic                wr_en;
   logic                ctrl_wr;
   logic                period_wr;
   logic                last_wr;
   logic                pat_wr;
   logic                pat_hit;
   logic [IDX_W-1:0]    pat_idx;

   // Helpers for the step decision
   logic [IDX_W-1:0]    idx_nxt;
   logic [PERIOD_W-1:0] period_eff;
   logic [DATA_W-1:0]   pat_first;
   logic [DATA_W-1:0]   pat_next;

   // Upper write-data bits have no register behind them
   logic                unused_wdata;

   assign wr_en     = chipselect && !write_n;
   assign pat_idx   = address[IDX_W-1:0];
   assign pat_hit   = address[3] && (int'(address[2:0]) < DEPTH);
   assign ctrl_wr   = wr_en && (address == 4'd0);
   assign period_wr = wr_en && (address == 4'd1);
   assign last_wr   = wr_en && (address == 4'd2);
   assign pat_wr    = wr_en && pat_hit;

   // Index increment wraps modulo DEPTH, so a LAST below the current index is
   // only matched again after the wrap through DEPTH-1.
   assign idx_nxt    = idx + 1'b1;
   assign period_eff = (period == '0) ? PERIOD_W'(1) : period;
   assign pat_first  = pattern[0];
   assign pat_next   = pattern[idx_nxt];

   assign pio_address  = 2'd0;
   assign unused_wdata = ^writedata[31:PERIOD_W];

   // Pattern table: written only by software, read by the sequencer and the slave mux
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            pattern[i] <= '0;
         end
      end else if (pat_wr) begin
         pattern[pat_idx] <= writedata[DATA_W-1:0];
      end
   end

   // Control registers and the step sequencer with registered PIO outputs.
   // Kept in one block because RUN and DONE are written by both software and
   // the sequencer; hardware updates are placed after software updates so that
   // DONE-set beats a same-cycle DONE-clear, while the RUN auto-clear is
   // suppressed when software writes CTRL in that cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= S_IDLE;
         run            <= 1'b0;
         loop           <= 1'b0;
         done           <= 1'b0;
         period         <= '0;
         last           <= '0;
         idx            <= '0;
         cnt            <= '0;
         busy           <= 1'b0;
         pio_chipselect <= 1'b0;
         pio_write_n    <= 1'b1;
         pio_writedata  <= '0;
      end else begin
         if (ctrl_wr) begin
            run  <= writedata[0];
            loop <= writedata[1];
            if (writedata[2]) begin
               done <= 1'b0;
            end
         end
         if (period_wr) begin
            period <= writedata[PERIOD_W-1:0];
         end
         if (last_wr) begin
            last <= writedata[IDX_W-1:0];
         end

         // The PIO write is a one-cycle pulse; every cycle that is not a
         // strobe returns the master port to its idle values.
         pio_chipselect <= 1'b0;
         pio_write_n    <= 1'b1;
         pio_writedata  <= '0;

         case (state)
            S_IDLE, S_DONE: begin
               if (run) begin
                  idx            <= '0;
                  done           <= 1'b0;
                  state          <= S_STROBE;
                  busy           <= 1'b1;
                  pio_chipselect <= 1'b1;
                  pio_write_n    <= 1'b0;
                  pio_writedata  <= 32'(pat_first);
               end
            end

            S_STROBE: begin
               // Strobe data was captured on entry; now arm the step timer.
               cnt   <= period_eff;
               state <= S_WAIT;
            end

            S_WAIT: begin
               if (cnt > PERIOD_W'(1)) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  cnt <= '0;
                  if (!run) begin
                     state <= S_IDLE;
                     busy  <= 1'b0;
                  end else if ((idx == last) && loop) begin
                     idx            <= '0;
                     state          <= S_STROBE;
                     pio_chipselect <= 1'b1;
                     pio_write_n    <= 1'b0;
                     pio_writedata  <= 32'(pat_first);
                  end else if (idx == last) begin
                     state <= S_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     if (!ctrl_wr) begin
                        run <= 1'b0;
                     end
                  end else begin
                     idx            <= idx_nxt;
                     state          <= S_STROBE;
                     pio_chipselect <= 1'b1;
                     pio_write_n    <= 1'b0;
                     pio_writedata  <= 32'(pat_next);
                  end
               end
            end

            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Zero-wait-state read mux; unmapped bits and addresses read as zero
   always_comb begin
      readdata = '0;
      case (address)
         4'd0: readdata = 32'({loop, run});
         4'd1: readdata = 32'(period);
         4'd2: readdata = 32'(last);
         4'd3: readdata = 32'({idx, 2'b00, done, busy});
         default: begin
            if (pat_hit) begin
               readdata = 32'(pattern[pat_idx]);
            end
         end
      endcase
   end

endmodule

// File: tb/tb_ledg_pattern_sequencer.sv
module tb_ledg_pattern_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        pio_chipselect;
   logic        pio_write_n;
   logic [1:0]  pio_address;
   logic [31:0] pio_writedata;
   logic        busy;

   ledg_pattern_sequencer dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .address        (address),
      .chipselect     (chipselect),
      .write_n        (write_n),
      .writedata      (writedata),
      .readdata       (readdata),
      .pio_chipselect (pio_chipselect),
      .pio_write_n    (pio_write_n),
      .pio_address    (pio_address),
      .pio_writedata  (pio_writedata),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   // Cycle number: count of rising edges seen so far
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: pattern table contents and the observed PIO writes
   logic [8:0] mdl_pat [8];
   logic [31:0] sq_dat [$];
   int          sq_cyc [$];

   // Record every PIO write strobe with the cycle it was seen in
   always @(negedge clk) begin
      if (reset_n === 1'b1 && pio_chipselect === 1'b1 && pio_write_n === 1'b0) begin
         sq_dat.push_back(pio_writedata);
         sq_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [3:0] a, input logic [31:0] d, output int ecyc);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
      ecyc       = cyc;
      if (a[3]) mdl_pat[a[2:0]] = d[8:0];
   endtask

   task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
      @(negedge clk);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      d          = readdata;
      chipselect = 1'b0;
   endtask

   // Advance to the falling edge inside cycle n
   task automatic wait_cyc(input int n);
      do @(negedge clk); while (cyc < n);
   endtask

   task automatic clear_q();
      sq_dat.delete();
      sq_cyc.delete();
   endtask

   task automatic check_all_zero(input string nm);
      logic [31:0] rd;
      for (int a = 0; a < 16; a++) begin
         bus_rd(4'(a), rd);
         chk($sformatf("%s_rd%0d", nm, a), rd, 32'h0);
      end
   endtask

   // One run: single-shot plays LAST+1 steps then DONE; loop plays two full
   // rounds plus one step and is then aborted.
   task automatic run_trial(input int per, input int lst, input bit lp, input string nm);
      int pe, n_exp, e, ea, nb, t;
      logic [31:0] rd;
      pe    = (per == 0) ? 1 : per;
      n_exp = lp ? 2 * (lst + 1) + 1 : lst + 1;
      bus_wr(4'd1, 32'(per), t);
      bus_wr(4'd2, 32'(lst), t);
      clear_q();
      bus_wr(4'd0, lp ? 32'h3 : 32'h1, e);
      wait_cyc(e + n_exp * (pe + 1) + 3);
      if (lp) chk({nm, "_cnt"}, 32'(sq_dat.size() >= n_exp), 32'h1);
      else    chk({nm, "_cnt"}, 32'(sq_dat.size()), 32'(n_exp));
      for (int k = 0; k < n_exp && k < sq_dat.size(); k++) begin
         chk($sformatf("%s_dat%0d", nm, k), sq_dat[k], 32'(mdl_pat[k % (lst + 1)]));
         chk($sformatf("%s_cyc%0d", nm, k), 32'(sq_cyc[k]), 32'(e + 1 + k * (pe + 1)));
      end
      if (!lp) begin
         bus_rd(4'd3, rd);
         chk({nm, "_status"}, rd, 32'((lst << 4) | 2));
         bus_rd(4'd0, rd);
         chk({nm, "_ctrl"}, rd, 32'h0);
         chk({nm, "_busy"}, 32'(busy), 32'h0);
      end else begin
         bus_wr(4'd0, 32'h2, ea);
         nb = sq_dat.size();
         wait_cyc(ea + pe + 4);
         chk({nm, "_abort_extra"}, 32'((sq_dat.size() - nb) <= 1), 32'h1);
         chk({nm, "_abort_busy"}, 32'(busy), 32'h0);
         bus_rd(4'd3, rd);
         chk({nm, "_abort_status"}, rd & 32'h3, 32'h0);
         bus_rd(4'd0, rd);
         chk({nm, "_abort_ctrl"}, rd, 32'h2);
      end
   endtask

   initial begin
      int e, t, nb;
      logic [31:0] rd;

      for (int i = 0; i < 8; i++) mdl_pat[i] = '0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_pio_cs", 32'(pio_chipselect), 32'h0);
      chk("rst_pio_wn", 32'(pio_write_n), 32'h1);
      chk("rst_busy", 32'(busy), 32'h0);
      reset_n = 1'b1;
      @(negedge clk);
      check_all_zero("rst");
      chk("rst_pio_addr", 32'(pio_address), 32'h0);

      // Single shot: 0x001, 0x002, 0x1FF four cycles apart
      bus_wr(4'd8, 32'h001, t);
      bus_wr(4'd9, 32'h002, t);
      bus_wr(4'd10, 32'h1FF, t);
      run_trial(3, 2, 1'b0, "ss");

      // Loop with a live edit of PATTERN[1] during the WAIT of step 0
      bus_wr(4'd1, 32'd3, t);
      bus_wr(4'd2, 32'd2, t);
      clear_q();
      bus_wr(4'd0, 32'h3, e);
      repeat (2) @(posedge clk);
      bus_wr(4'd9, 32'h155, t);
      wait_cyc(e + 30);
      chk("lp_cnt", 32'(sq_dat.size() >= 7), 32'h1);
      for (int k = 0; k < 7 && k < sq_dat.size(); k++) begin
         chk($sformatf("lp_dat%0d", k), sq_dat[k], 32'(mdl_pat[k % 3]));
         chk($sformatf("lp_cyc%0d", k), 32'(sq_cyc[k]), 32'(e + 1 + 4 * k));
      end
      chk("lp_edit", (sq_dat.size() > 1) ? sq_dat[1] : 32'hDEAD, 32'h155);
      bus_wr(4'd0, 32'h2, e);
      nb = sq_dat.size();
      wait_cyc(e + 8);
      chk("lp_abort_extra", 32'((sq_dat.size() - nb) <= 1), 32'h1);
      chk("lp_abort_busy", 32'(busy), 32'h0);

      // PERIOD=0 behaves as 1; DONE two cycles after the strobe; DONE clear
      bus_wr(4'd8, 32'h0AA, t);
      bus_wr(4'd1, 32'd0, t);
      bus_wr(4'd2, 32'd0, t);
      bus_wr(4'd0, 32'h1, e);
      wait_cyc(e + 1);
      chk("p0_cs", 32'(pio_chipselect), 32'h1);
      chk("p0_wn", 32'(pio_write_n), 32'h0);
      chk("p0_dat", pio_writedata, 32'h0AA);
      wait_cyc(e + 2);
      chk("p0_cs_off", 32'(pio_chipselect), 32'h0);
      chk("p0_dat_off", pio_writedata, 32'h0);
      chk("p0_busy_wait", 32'(busy), 32'h1);
      wait_cyc(e + 3);
      chk("p0_busy_done", 32'(busy), 32'h0);
      bus_rd(4'd3, rd);
      chk("p0_status", rd, 32'h02);
      bus_wr(4'd0, 32'h4, t);
      bus_rd(4'd3, rd);
      chk("p0_status_clr", rd, 32'h00);
      bus_rd(4'd0, rd);
      chk("p0_ctrl", rd, 32'h0);

      // Randomized runs against the model
      for (int tr = 0; tr < 6; tr++) begin
         for (int i = 0; i < 8; i++) bus_wr(4'(8 + i), 32'($urandom_range(0, 511)), t);
         run_trial(int'($urandom_range(0, 6)), int'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), $sformatf("r%0d", tr));
      end

      // Reset asserted in the middle of a strobe
      bus_wr(4'd8, 32'h123, t);
      bus_wr(4'd1, 32'd5, t);
      bus_wr(4'd2, 32'd3, t);
      bus_wr(4'd0, 32'h3, e);
      wait_cyc(e + 1);
      chk("mr_strobe_on", 32'(pio_chipselect), 32'h1);
      reset_n = 1'b0;
      #1;
      chk("mr_cs", 32'(pio_chipselect), 32'h0);
      chk("mr_wn", 32'(pio_write_n), 32'h1);
      chk("mr_dat", pio_writedata, 32'h0);
      chk("mr_busy", 32'(busy), 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 8; i++) mdl_pat[i] = '0;
      check_all_zero("mr");

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
